// File: rtl/pwm_expander_pkg.sv
// -----------------------------------------------------------------------------
// pwm_expander_pkg
// Shared constants for the SPI-controlled PWM expander: command-field layout,
// control/prescale register addresses, control bit indices and the SPI frame
// receiver state encoding.
// -----------------------------------------------------------------------------
package pwm_expander_pkg;

  // Command byte: bit7 = write(1)/read(0), bits6:0 = register address.
  localparam int CMD_BITS     = 8;
  localparam int CMD_WR_BIT   = 7;
  localparam int CMD_ADDR_MSB = 6;
  localparam int CMD_ADDR_LSB = 0;
  localparam int ADDR_W       = CMD_ADDR_MSB - CMD_ADDR_LSB + 1;

  // Register map outside the per-channel duty registers.
  localparam logic [ADDR_W-1:0] ADDR_CTRL     = 7'h7E;
  localparam logic [ADDR_W-1:0] ADDR_PRESCALE = 7'h7F;

  // CTRL register bits.
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_INV_BIT = 1;

  // SPI frame receiver phases.
  typedef enum logic [1:0] {
    SPI_IDLE = 2'd0,
    SPI_CMD  = 2'd1,
    SPI_DATA = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_frame_slave.sv
// -----------------------------------------------------------------------------
// spi_frame_slave
// SPI mode-0 frame receiver running entirely in the system clock domain.
// CS/SCLK/MOSI pass through 2-flop synchronisers; SCLK edges are detected on
// the synchronised copy. A frame is an 8-bit command followed by RES data bits.
//
// Ports:
//   clk_i, rst_i     system clock, async active-high reset
//   cs_n_i           SPI chip select (active low, asynchronous)
//   sclk_i, mosi_i   SPI clock / data in (asynchronous)
//   rd_data_i        register value for rd_addr_o, sampled on rd_stb_o
//   rd_stb_o         pulse: read command complete, load rd_data_i
//   rd_addr_o        address of the read in progress (valid with rd_stb_o)
//   wr_stb_o         pulse: complete write frame committed on CS rise
//   wr_addr_o        write address (valid with wr_stb_o)
//   wr_data_o        write data (valid with wr_stb_o)
//   miso_bit_o       current MSB of the read shift register
//   state_o          receiver phase, for observation
//
// Strobe protocol: rd_stb_o and wr_stb_o are single-cycle pulses with no
// back-pressure; the consumer must act in the cycle the strobe is high, while
// the accompanying address/data outputs are valid.
// -----------------------------------------------------------------------------
module spi_frame_slave
  import pwm_expander_pkg::*;
#(
  parameter int RES = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cs_n_i,
  input  logic              sclk_i,
  input  logic              mosi_i,
  input  logic [RES-1:0]    rd_data_i,
  output logic              rd_stb_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              wr_stb_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [RES-1:0]    wr_data_o,
  output logic              miso_bit_o,
  output spi_state_e        state_o
);

  localparam int FRAME_BITS = CMD_BITS + RES;
  localparam int CNT_W      = 6;
  localparam logic [CNT_W-1:0] CNT_FRAME    = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_CMD      = CNT_W'(CMD_BITS);
  localparam logic [CNT_W-1:0] CNT_CMD_LAST = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  logic                  sclk_rise, sclk_fall, cs_rise, cs_fall;
  spi_state_e            state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [RES-1:0]        miso_sr_q;

  // Synchronisers plus one history flop for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cs_meta_q   <= 1'b0;
      cs_sync_q   <= 1'b0;
      cs_prev_q   <= 1'b0;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      cs_meta_q   <= cs_n_i;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      sclk_meta_q <= sclk_i;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      mosi_meta_q <= mosi_i;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
  assign cs_rise   = cs_sync_q & ~cs_prev_q;
  assign cs_fall   = ~cs_sync_q & cs_prev_q;

  // A frame only starts on an observed CS falling edge, so a reset that
  // lands mid-frame leaves the receiver idle until CS is re-asserted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= SPI_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SPI_IDLE: if (cs_fall) state_d = SPI_CMD;
      SPI_CMD: begin
        if (cs_sync_q)                                  state_d = SPI_IDLE;
        else if (sclk_rise && bit_cnt_q == CNT_CMD_LAST) state_d = SPI_DATA;
      end
      SPI_DATA: if (cs_sync_q) state_d = SPI_IDLE;
      default: state_d = SPI_IDLE;
    endcase
  end

  // Read strobe fires on the 8th rising edge; the incoming bit completes the
  // address, and the first-received (R/W) bit now sits at shift_q[6].
  assign rd_stb_o  = (state_q == SPI_CMD) && sclk_rise &&
                     (bit_cnt_q == CNT_CMD_LAST) && !shift_q[CMD_WR_BIT-1];
  assign rd_addr_o = {shift_q[ADDR_W-2:0], mosi_sync_q};

  // Writes need exactly CMD_BITS+RES bits; the counter saturates so long
  // frames cannot wrap back onto a valid count.
  assign wr_stb_o  = (state_q == SPI_DATA) && cs_rise &&
                     (bit_cnt_q == CNT_FRAME) && shift_q[FRAME_BITS-1];
  assign wr_addr_o = shift_q[FRAME_BITS-2 -: ADDR_W];
  assign wr_data_o = shift_q[RES-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      miso_sr_q <= '0;
    end else if (cs_fall) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      miso_sr_q <= '0;
    end else begin
      if (state_q != SPI_IDLE && sclk_rise) begin
        shift_q <= {shift_q[FRAME_BITS-2:0], mosi_sync_q};
        if (bit_cnt_q != CNT_MAX) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
      // The falling edge right after the 8th rising edge must not shift:
      // the master has not yet sampled the MSB.
      if (rd_stb_o)
        miso_sr_q <= rd_data_i;
      else if (state_q == SPI_DATA && sclk_fall && bit_cnt_q > CNT_CMD)
        miso_sr_q <= {miso_sr_q[RES-2:0], 1'b0};
    end
  end

  assign miso_bit_o = miso_sr_q[RES-1];
  assign state_o    = state_q;

endmodule

// File: rtl/multi_channel_pwm_expander.sv
// -----------------------------------------------------------------------------
// multi_channel_pwm_expander
// SPI-programmable bank of PWM outputs. Duty registers are double-buffered:
// SPI writes land in shadow registers that are copied to the active set only
// when the period counter wraps, so waveforms never glitch mid-period.
//
// Ports:
//   CLK         system clock (all logic on rising edge)
//   RST         asynchronous active-high reset
//   CS          SPI chip select, active low
//   SCLK, MOSI  SPI mode-0 clock and data in, MSB first
//   MISO        SPI data out, MSB first, 0 outside the read data phase
//   PWMOutputs  registered PWM waveforms, bit i = channel i
// -----------------------------------------------------------------------------
module multi_channel_pwm_expander
  import pwm_expander_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int RES      = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CS,
  input  logic                SCLK,
  input  logic                MOSI,
  output logic                MISO,
  output logic [CHANNELS-1:0] PWMOutputs
);

  // Period counter runs 0 .. 2^RES-2, so a duty of 2^RES-1 is always high.
  localparam logic [RES-1:0] PERIOD_LAST = RES'((1 << RES) - 2);

  logic              rd_stb, wr_stb, miso_bit;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [RES-1:0]    wr_data, rd_data;
  spi_state_e        spi_state;

  logic                ctrl_en_q, ctrl_inv_q;
  logic [RES-1:0]      prescale_q;
  logic [RES-1:0]      presc_cnt_q, presc_cnt_d;
  logic [RES-1:0]      period_q, period_d;
  logic                tick, period_wrap;
  logic [RES-1:0]      shadow_q [CHANNELS];
  logic [RES-1:0]      active_q [CHANNELS];
  logic [CHANNELS-1:0] raw;
  logic [CHANNELS-1:0] pwm_q;

  spi_frame_slave #(.RES(RES)) u_spi (
    .clk_i      (CLK),
    .rst_i      (RST),
    .cs_n_i     (CS),
    .sclk_i     (SCLK),
    .mosi_i     (MOSI),
    .rd_data_i  (rd_data),
    .rd_stb_o   (rd_stb),
    .rd_addr_o  (rd_addr),
    .wr_stb_o   (wr_stb),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .miso_bit_o (miso_bit),
    .state_o    (spi_state)
  );

  // MISO only carries read data during the data phase; a CS rise returns
  // the receiver to idle and forces MISO low.
  assign MISO = miso_bit & (spi_state == SPI_DATA);

  // Register read mux; reads return the shadow (programmed) duty values.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data = shadow_q[i];
    end
    if (rd_addr == ADDR_CTRL) begin
      rd_data               = '0;
      rd_data[CTRL_EN_BIT]  = ctrl_en_q;
      rd_data[CTRL_INV_BIT] = ctrl_inv_q;
    end
    if (rd_addr == ADDR_PRESCALE) rd_data = prescale_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ctrl_en_q  <= 1'b0;
      ctrl_inv_q <= 1'b0;
      prescale_q <= '0;
    end else if (wr_stb) begin
      if (wr_addr == ADDR_CTRL) begin
        ctrl_en_q  <= wr_data[CTRL_EN_BIT];
        ctrl_inv_q <= wr_data[CTRL_INV_BIT];
      end
      if (wr_addr == ADDR_PRESCALE) prescale_q <= wr_data;
    end
  end

  // Prescaler and period counter. A count above a freshly lowered PRESCALE
  // wraps silently to 0 rather than running up to the register width.
  always_comb begin
    presc_cnt_d = presc_cnt_q;
    period_d    = period_q;
    tick        = 1'b0;
    period_wrap = 1'b0;
    if (!ctrl_en_q) begin
      presc_cnt_d = '0;
      period_d    = '0;
    end else begin
      if (presc_cnt_q > prescale_q) begin
        presc_cnt_d = '0;
      end else if (presc_cnt_q == prescale_q) begin
        presc_cnt_d = '0;
        tick        = 1'b1;
      end else begin
        presc_cnt_d = presc_cnt_q + RES'(1);
      end
      if (tick) begin
        if (period_q == PERIOD_LAST) begin
          period_d    = '0;
          period_wrap = 1'b1;
        end else begin
          period_d = period_q + RES'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_cnt_q <= '0;
      period_q    <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      period_q    <= period_d;
    end
  end

  // Shadow writes and active copies share a clock edge; the copy sees the
  // old shadow value, so a write coinciding with a wrap waits one period.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_stb && wr_addr == ADDR_W'(i)) shadow_q[i] <= wr_data;
        if (!ctrl_en_q || period_wrap)       active_q[i] <= shadow_q[i];
      end
    end
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      raw[i] = ctrl_en_q && (period_q < active_q[i]);
    end
  end

  // Invert is applied after enable gating, so a disabled, inverted bank
  // drives all ones.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pwm_q <= '0;
    else     pwm_q <= raw ^ {CHANNELS{ctrl_inv_q}};
  end

  assign PWMOutputs = pwm_q;

endmodule

// File: tb/tb_multi_channel_pwm_expander.sv
// -----------------------------------------------------------------------------
// tb_multi_channel_pwm_expander
// Directed bench for the SPI PWM expander (CHANNELS=4, RES=8). A small
// register model supplies expected read-back values; a period monitor keyed
// on channel 0 rising edges logs channel 1 high time per PWM period.
// -----------------------------------------------------------------------------
module tb_multi_channel_pwm_expander;

  localparam int CHANNELS = 4;
  localparam int RES      = 8;
  localparam int H        = 6;   // SCLK half period in CLK cycles

  logic                CLK = 1'b0;
  logic                RST;
  logic                CS;
  logic                SCLK;
  logic                MOSI;
  logic                MISO;
  logic [CHANNELS-1:0] PWMOutputs;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];

  // Register model.
  logic [RES-1:0] m_duty [CHANNELS];
  logic [1:0]     m_ctrl;
  logic [RES-1:0] m_presc;

  // Period monitor state.
  int   period_cnt = 0;
  int   hi_cnt     = 0;
  int   edge_cnt   = 0;
  int   hi_log   [256];
  int   edge_log [256];
  logic ch0_prev = 1'b0;
  logic ch1_prev = 1'b0;

  multi_channel_pwm_expander #(.CHANNELS(CHANNELS), .RES(RES)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .CS         (CS),
    .SCLK       (SCLK),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .PWMOutputs (PWMOutputs)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- period monitor ----------------
  always @(negedge CLK) begin
    if (PWMOutputs[0] && !ch0_prev) begin
      if (period_cnt < 256) begin
        hi_log[period_cnt]   = hi_cnt;
        edge_log[period_cnt] = edge_cnt;
      end
      period_cnt++;
      hi_cnt   = 0;
      edge_cnt = 0;
    end
    if (PWMOutputs[1])              hi_cnt++;
    if (PWMOutputs[1] && !ch1_prev) edge_cnt++;
    ch0_prev = PWMOutputs[0];
    ch1_prev = PWMOutputs[1];
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_until_period(input int target);
    int budget;
    budget = 0;
    while (period_cnt < target && budget < 5000) begin
      @(negedge CLK);
      budget++;
    end
    if (period_cnt < target) check("period_timeout", 32'(period_cnt), 32'(target));
  endtask

  // Drives one SPI mode-0 frame of nbits; samples MISO just before each
  // rising edge. keep_cs leaves CS asserted at the end.
  task automatic spi_frame(input logic [7:0] cmd, input logic [RES-1:0] data,
                           input int nbits, input bit keep_cs,
                           output logic [RES-1:0] rd, output int cmd_ones);
    logic [15:0] fb;
    fb       = {cmd, data};
    rd       = '0;
    cmd_ones = 0;
    CS = 1'b0;
    wait_clk(H);
    for (int i = 0; i < nbits; i++) begin
      MOSI = (i < 16) ? fb[15-i] : 1'b0;
      wait_clk(H);
      if (i < 8)       cmd_ones += int'(MISO);
      else if (i < 16) rd[15-i] = MISO;
      SCLK = 1'b1;
      wait_clk(H);
      SCLK = 1'b0;
    end
    MOSI = 1'b0;
    wait_clk(H);
    if (!keep_cs) begin
      CS = 1'b1;
      wait_clk(2*H);
    end
  endtask

  function automatic logic [RES-1:0] model_read(input logic [6:0] a);
    if (a < 7'(CHANNELS)) return m_duty[a[1:0]];
    if (a == 7'h7E)       return {6'b0, m_ctrl};
    if (a == 7'h7F)       return m_presc;
    return '0;
  endfunction

  task automatic write_reg(input logic [6:0] a, input logic [RES-1:0] d);
    logic [RES-1:0] rd;
    int             ones;
    spi_frame({1'b1, a}, d, 16, 1'b0, rd, ones);
    if (a < 7'(CHANNELS)) m_duty[a[1:0]] = d;
    else if (a == 7'h7E)  m_ctrl = d[1:0];
    else if (a == 7'h7F)  m_presc = d;
  endtask

  task automatic read_reg(input logic [6:0] a, input string tag);
    logic [RES-1:0] rd;
    int             ones;
    logic [15:0]    e;
    exp_q.push_back(16'(model_read(a)));
    spi_frame({1'b0, a}, '0, 16, 1'b0, rd, ones);
    e = exp_q.pop_front();
    check(tag, 32'(rd), 32'(e));
    check({tag, "_cmd_miso"}, 32'(ones), 32'd0);
  endtask

  task automatic count_window(input int n, output int c0, output int c1,
                              output int c2, output int c3);
    c0 = 0; c1 = 0; c2 = 0; c3 = 0;
    repeat (n) begin
      @(negedge CLK);
      c0 += int'(PWMOutputs[0]);
      c1 += int'(PWMOutputs[1]);
      c2 += int'(PWMOutputs[2]);
      c3 += int'(PWMOutputs[3]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CHANNELS; i++) m_duty[i] = '0;
    m_ctrl  = '0;
    m_presc = '0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int             c0, c1, c2, c3, b, ones;
    logic [RES-1:0] rd;
    logic [15:0]    e;

    RST = 1'b1; CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    model_reset();
    wait_clk(3);
    check("rst_pwm", 32'(PWMOutputs), 32'd0);
    check("rst_miso", 32'(MISO), 32'd0);
    RST = 1'b0;
    wait_clk(4);
    read_reg(7'h7E, "rst_ctrl");

    // 50% duty on ch0 at full rate: 128 high of every 255 CLK.
    write_reg(7'h00, 8'h80);
    write_reg(7'h7F, 8'h00);
    write_reg(7'h7E, 8'h01);
    wait_clk(20);
    count_window(510, c0, c1, c2, c3);
    check("ch0_high_2periods", 32'(c0), 32'd256);
    check("ch123_idle", 32'(c1 + c2 + c3), 32'd0);
    read_reg(7'h00, "rd_ch0");

    write_reg(7'h10, 8'h5A);
    read_reg(7'h10, "rd_unmapped");

    // Mid-period duty change on ch1 (PRESCALE=1, period = 510 CLK).
    write_reg(7'h7F, 8'h01);
    write_reg(7'h01, 8'hC0);
    wait_until_period(period_cnt + 2);
    wait_until_period(period_cnt + 1);
    b = period_cnt;
    exp_q.push_back(16'd384);
    exp_q.push_back(16'd128);
    write_reg(7'h01, 8'h40);
    wait_until_period(b + 2);
    e = exp_q.pop_front();
    check("ch1_current_period_high", 32'(hi_log[b]), 32'(e));
    e = exp_q.pop_front();
    check("ch1_next_period_high", 32'(hi_log[b+1]), 32'(e));
    check("ch1_current_period_edges", 32'(edge_log[b]), 32'd1);
    check("ch1_next_period_edges", 32'(edge_log[b+1]), 32'd1);

    // Duty extremes with invert.
    write_reg(7'h02, 8'h00);
    write_reg(7'h03, 8'hFF);
    write_reg(7'h7E, 8'h03);
    wait_clk(1100);
    count_window(510, c0, c1, c2, c3);
    check("inv_ch0_high", 32'(c0), 32'd254);
    check("inv_ch1_high", 32'(c1), 32'd382);
    check("inv_ch2_const_high", 32'(c2), 32'd510);
    check("inv_ch3_const_low", 32'(c3), 32'd0);

    // PRESCALE read-back through MISO.
    write_reg(7'h7F, 8'h05);
    read_reg(7'h7F, "rd_prescale");
    wait_clk(2);
    check("miso_idle_after_read", 32'(MISO), 32'd0);

    // Truncated and over-long write frames are discarded.
    spi_frame({1'b1, 7'h00}, 8'h20, 15, 1'b0, rd, ones);
    read_reg(7'h00, "trunc15_ch0");
    spi_frame({1'b1, 7'h00}, 8'h20, 17, 1'b0, rd, ones);
    read_reg(7'h00, "long17_ch0");
    read_reg(7'h7E, "ctrl_kept");

    // CS rising mid-read forces MISO low within 3 CLK.
    spi_frame({1'b0, 7'h03}, 8'h00, 11, 1'b1, rd, ones);
    check("partial_read_bits", 32'(rd[7:5]), 32'd7);
    check("miso_mid_read", 32'(MISO), 32'd1);
    CS = 1'b1;
    wait_clk(3);
    check("miso_after_cs_rise", 32'(MISO), 32'd0);
    wait_clk(10);

    // Reset pulse in the middle of a read frame.
    spi_frame({1'b0, 7'h03}, 8'h00, 10, 1'b1, rd, ones);
    check("miso_before_rst", 32'(MISO), 32'd1);
    check("pwm_before_rst_nonzero", 32'(PWMOutputs != '0), 32'd1);
    RST = 1'b1;
    #1;
    check("rst_mid_frame_pwm", 32'(PWMOutputs), 32'd0);
    check("rst_mid_frame_miso", 32'(MISO), 32'd0);
    wait_clk(3);
    RST = 1'b0;
    wait_clk(4);
    CS = 1'b1;
    wait_clk(4);
    model_reset();
    check("pwm_after_rst", 32'(PWMOutputs), 32'd0);
    read_reg(7'h00, "post_rst_ch0");
    read_reg(7'h01, "post_rst_ch1");
    read_reg(7'h02, "post_rst_ch2");
    read_reg(7'h03, "post_rst_ch3");
    read_reg(7'h7E, "post_rst_ctrl");
    read_reg(7'h7F, "post_rst_prescale");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
